// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an NDIG-digit common-anode
// 7-segment display using the custom 16-entry glyph set. Holds a
// double-buffered frame of glyph codes, scans one digit per slot and blanks
// all anodes for the first BLANK cycles of each slot.
// Optional blinking is built when SEG7_SCAN_BLINK_EN is defined.
module seg7_scan_driver #(
  parameter int NDIG         = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK        = 8,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ld,
  input  logic [4*NDIG-1:0] codes,
  input  logic [NDIG-1:0]   blink_mask,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              pend,
  output logic              frame_sync
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);
  localparam logic [3:0]       BLANK_CODE = 4'h2;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4*NDIG-1:0] shd_codes_q, shd_codes_d;
  logic [4*NDIG-1:0] act_codes_q, act_codes_d;
  logic              pend_q, pend_d;
  logic              frame_sync_q, frame_sync_d;
  logic [6:0]        seg_q, seg_d;
  logic [NDIG-1:0]   an_q, an_d;

  logic              slot_wrap;
  logic              boundary;
  logic              in_blank;
  logic              cur_supp;
  logic [3:0]        cur_code;
  logic [NDIG-1:0]   an_lit;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] g;
    case (c)
      4'h0:    g = 7'b0111001;
      4'h1:    g = 7'b1000100;
      4'h4:    g = 7'b1001000;
      4'h5:    g = 7'b1111110;
      4'h6:    g = 7'b0001001;
      4'h7:    g = 7'b0001000;
      4'h8:    g = 7'b0100100;
      4'hD:    g = 7'b0001001;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111001;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign slot_wrap = (cnt_q == CNT_LAST);
  assign boundary  = slot_wrap && (idx_q == IDX_LAST);

  // A zero-length blanking gap would make the compare constant, so it is
  // resolved at elaboration instead.
  if (BLANK > 0) begin : g_blank
    // Anodes stay off for the first BLANK cycles of every slot.
    always_comb in_blank = (cnt_q < CNT_W'(BLANK));
  end else begin : g_no_blank
    // No blanking gap configured.
    always_comb in_blank = 1'b0;
  end

`ifdef SEG7_SCAN_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

  logic [NDIG-1:0] shd_mask_q, shd_mask_d;
  logic [NDIG-1:0] act_mask_q, act_mask_d;
  logic [BC_W-1:0] bcnt_q, bcnt_d;
  logic            phase_q, phase_d;

  // Blink masks follow the same shadow/active double buffer as the codes;
  // the phase toggles every BLINK_FRAMES frame boundaries.
  always_comb begin
    shd_mask_d = shd_mask_q;
    act_mask_d = act_mask_q;
    bcnt_d     = bcnt_q;
    phase_d    = phase_q;
    if (boundary && pend_q) act_mask_d = shd_mask_q;
    if (ld)                 shd_mask_d = blink_mask;
    if (boundary) begin
      if (bcnt_q == BC_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BC_W'(1);
      end
    end
  end

  // Suppress the current digit while in the off phase and its mask bit is set.
  always_comb begin
    cur_supp = 1'b0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (idx_q == IDX_W'(k)) cur_supp = phase_q & act_mask_q[k];
    end
  end

  // Blink state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shd_mask_q <= '0;
      act_mask_q <= '0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
    end else begin
      shd_mask_q <= shd_mask_d;
      act_mask_q <= act_mask_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
    end
  end
`else
  logic unused_blink;

  // Blinking not built: the mask port is accepted but ignored.
  always_comb begin
    unused_blink = ^blink_mask;
    cur_supp     = 1'b0;
  end
`endif

  // Select the active glyph code and anode pattern for the current digit.
  always_comb begin
    cur_code = BLANK_CODE;
    an_lit   = '1;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_code  = act_codes_q[4*k +: 4];
        an_lit[k] = 1'b0;
      end
    end
  end

  // Scan counters, frame double buffering and registered display outputs.
  // The transfer uses the pre-edge shadow, then a coincident ld refills it
  // and re-asserts pend, so set wins over the boundary clear.
  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    shd_codes_d  = shd_codes_q;
    act_codes_d  = act_codes_q;
    pend_d       = pend_q;
    frame_sync_d = boundary;
    seg_d        = 7'h7F;
    an_d         = '1;

    if (slot_wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (boundary && pend_q) begin
      act_codes_d = shd_codes_q;
      pend_d      = 1'b0;
    end

    if (ld) begin
      shd_codes_d = codes;
      pend_d      = 1'b1;
    end

    if (!in_blank) begin
      an_d  = an_lit;
      seg_d = cur_supp ? 7'h7F : glyph(cur_code);
    end
  end

  // Core state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shd_codes_q  <= {NDIG{BLANK_CODE}};
      act_codes_q  <= {NDIG{BLANK_CODE}};
      pend_q       <= 1'b0;
      frame_sync_q <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shd_codes_q  <= shd_codes_d;
      act_codes_q  <= act_codes_d;
      pend_q       <= pend_d;
      frame_sync_q <= frame_sync_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign pend       = pend_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NDIG=4, PRESCALE=10, BLANK=2,
// BLINK_FRAMES=2. Every output cycle is checked against the frame the
// sequence expects to be on display; pend and key glyphs are checked by hand.
module tb_seg7_scan_driver;

  logic        CLK;
  logic        RST_N;
  logic        ld;
  logic [15:0] codes;
  logic [3:0]  blink_mask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pend;
  logic        frame_sync;

  int          tests;
  int          fails;
  int          e;
  logic [15:0] disp_codes;
  logic [3:0]  disp_supp;

  seg7_scan_driver #(
    .NDIG         (4),
    .PRESCALE     (10),
    .BLANK        (2),
    .BLINK_FRAMES (2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ld         (ld),
    .codes      (codes),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an),
    .pend       (pend),
    .frame_sync (frame_sync)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [6:0] exp_glyph(input logic [3:0] c);
    logic [6:0] g;
    case (c)
      4'h0:    g = 7'h39;
      4'h1:    g = 7'h44;
      4'h4:    g = 7'h48;
      4'h5:    g = 7'h7E;
      4'h6:    g = 7'h09;
      4'h7:    g = 7'h08;
      4'h8:    g = 7'h24;
      4'hD:    g = 7'h09;
      4'hE:    g = 7'h30;
      4'hF:    g = 7'h39;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %h, expected %h", tag, e, obs, expv);
    end
  endtask

  // Advance one clock, sample at the falling edge and check the scan output.
  task automatic step();
    int         p;
    int         d;
    logic [3:0] c;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    @(posedge CLK);
    @(negedge CLK);
    e++;
    p = (e - 1) % 10;
    d = ((e - 1) / 10) % 4;
    c = disp_codes[4*d +: 4];
    exp_an = 4'hF;
    exp_seg = 7'h7F;
    if (p >= 2) begin
      exp_an[d] = 1'b0;
      exp_seg   = disp_supp[d] ? 7'h7F : exp_glyph(c);
    end
    chk("scan_an", {28'd0, an}, {28'd0, exp_an});
    chk("scan_seg", {25'd0, seg}, {25'd0, exp_seg});
    chk("frame_sync", {31'd0, frame_sync}, {31'd0, (e % 40 == 0)});
  endtask

  task automatic step_to(input int n);
    while (e < n) step();
  endtask

  task automatic ld_pulse(input logic [15:0] c, input logic [3:0] m);
    ld         = 1'b1;
    codes      = c;
    blink_mask = m;
    step();
    ld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests      = 0;
    fails      = 0;
    e          = 0;
    disp_codes = 16'h2222;
    disp_supp  = 4'h0;
    RST_N      = 1'b0;
    ld         = 1'b0;
    codes      = 16'h0000;
    blink_mask = 4'h0;

    repeat (3) @(negedge CLK);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_pend", {31'd0, pend}, 32'h0);
    chk("rst_fs", {31'd0, frame_sync}, 32'h0);

    RST_N = 1'b1;
    chk("rel_an", {28'd0, an}, 32'hF);
    chk("rel_seg", {25'd0, seg}, 32'h7F);
    step_to(3);
    chk("first_lit_an", {28'd0, an}, 32'hE);
    chk("first_lit_seg", {25'd0, seg}, 32'h7F);
    chk("first_pend", {31'd0, pend}, 32'h0);

    // Load F,E,D,0 (digit3..0).
    step_to(4);
    ld_pulse(16'hFED0, 4'h0);
    chk("pend_set", {31'd0, pend}, 32'h1);
    step_to(39);
    chk("pend_hold", {31'd0, pend}, 32'h1);
    step_to(40);
    chk("pend_clr", {31'd0, pend}, 32'h0);
    chk("fs_pulse", {31'd0, frame_sync}, 32'h1);
    disp_codes = 16'hFED0;
    step_to(41);
    chk("fs_one_cycle", {31'd0, frame_sync}, 32'h0);
    step_to(43);
    chk("d0_an", {28'd0, an}, 32'hE);
    chk("d0_seg", {25'd0, seg}, 32'h39);

    // Two loads in one frame: last one wins.
    step_to(50);
    ld_pulse(16'h2224, 4'h0);
    step_to(60);
    ld_pulse(16'h2227, 4'h0);
    chk("pend_reload", {31'd0, pend}, 32'h1);
    step_to(80);
    chk("pend_clr2", {31'd0, pend}, 32'h0);
    disp_codes = 16'h2227;
    step_to(83);
    chk("last_wins_seg", {25'd0, seg}, 32'h08);

    // Load coincident with the boundary.
    step_to(90);
    ld_pulse(16'h2255, 4'h0);
    step_to(119);
    ld_pulse(16'h2266, 4'h0);
    chk("pend_set_wins", {31'd0, pend}, 32'h1);
    disp_codes = 16'h2255;
    step_to(123);
    chk("old_shadow_seg", {25'd0, seg}, 32'h7E);
    step_to(160);
    chk("pend_clr3", {31'd0, pend}, 32'h0);
    disp_codes = 16'h2266;
    step_to(163);
    chk("new_shadow_seg", {25'd0, seg}, 32'h09);

    // Blink mask on digit0; phase is 1 during frames 6 and 7 after reset.
    step_to(170);
    ld_pulse(16'h8451, 4'b0001);
    step_to(200);
    disp_codes = 16'h8451;
    step_to(240);
`ifdef SEG7_SCAN_BLINK_EN
    disp_supp = 4'b0001;
`endif
    step_to(243);
    chk("blink_an", {28'd0, an}, 32'hE);
`ifdef SEG7_SCAN_BLINK_EN
    chk("blink_seg", {25'd0, seg}, 32'h7F);
`else
    chk("blink_seg", {25'd0, seg}, 32'h44);
`endif
    step_to(320);
    disp_supp = 4'h0;
    step_to(323);
    chk("unblink_seg", {25'd0, seg}, 32'h44);
    step_to(360);

    // Asynchronous reset mid-slot with a load pending.
    step_to(362);
    ld_pulse(16'h0000, 4'h0);
    chk("pend_before_rst", {31'd0, pend}, 32'h1);
    step_to(365);
    chk("lit_before_rst", {28'd0, an}, 32'hE);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_an", {28'd0, an}, 32'hF);
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_pend", {31'd0, pend}, 32'h0);
    chk("async_rst_fs", {31'd0, frame_sync}, 32'h0);
    repeat (2) @(negedge CLK);
    RST_N      = 1'b1;
    e          = 0;
    disp_codes = 16'h2222;
    disp_supp  = 4'h0;
    step_to(3);
    chk("rst2_an", {28'd0, an}, 32'hE);
    chk("rst2_seg", {25'd0, seg}, 32'h7F);
    step_to(40);
    chk("rst2_pend", {31'd0, pend}, 32'h0);
    step_to(43);
    chk("rst2_frame_seg", {25'd0, seg}, 32'h7F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
